// File: rtl/multicycle_controller_if.sv
// Handshake/strobe bundle between the multicycle controller (master) and its
// datapath/memory (slave).
interface multicycle_controller_if #(
  parameter int OPW = 8,
  parameter int SPW = 3
);
  logic [OPW-1:0] opcode;
  logic           NFLG;
  logic           ZFLG;
  logic           MEM_READY;
  logic           IRQ;

  logic           LOAD_AC;
  logic           LOAD_IRU;
  logic           LOAD_IRL;
  logic           LOAD_PC;
  logic           INCR_PC;
  logic           FETCH;
  logic           STORE_MEM;
  logic           READ_MEM;
  logic           PUSH_RET;
  logic           POP_RET;
  logic           IRQ_ACK;

  logic [SPW-1:0] SP;
  logic           STK_FULL;
  logic           STK_EMPTY;
  logic           HALTED;
  logic           FAULT;
  logic [3:0]     STATE;

  modport master (
    input  opcode, NFLG, ZFLG, MEM_READY, IRQ,
    output LOAD_AC, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH,
           STORE_MEM, READ_MEM, PUSH_RET, POP_RET, IRQ_ACK,
           SP, STK_FULL, STK_EMPTY, HALTED, FAULT, STATE
  );

  modport slave (
    output opcode, NFLG, ZFLG, MEM_READY, IRQ,
    input  LOAD_AC, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH,
           STORE_MEM, READ_MEM, PUSH_RET, POP_RET, IRQ_ACK,
           SP, STK_FULL, STK_EMPTY, HALTED, FAULT, STATE
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller with return-stack pointer,
// maskable interrupt entry, halt and fault states. State updates on falling clk.
module multicycle_controller #(
  parameter int OPW       = 8,
  parameter int STK_DEPTH = 4,
  parameter int SPW       = $clog2(STK_DEPTH + 1)
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_PREPU    = 4'd1,
    S_FETCHU   = 4'd2,
    S_PREPL    = 4'd3,
    S_FETCHL   = 4'd4,
    S_EXEC     = 4'd5,
    S_STOREMEM = 4'd6,
    S_READMEM  = 4'd7,
    S_JUMP     = 4'd8,
    S_CALL     = 4'd9,
    S_RET      = 4'd10,
    S_IRQ      = 4'd11,
    S_HALT     = 4'd12,
    S_FAULT    = 4'd13
  } state_e;

  state_e         state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           mask_q, mask_d;

  logic [7:0] op;
  logic       illegal;
  logic       stk_full;
  logic       stk_empty;
  logic       irq_take;

  logic load_ac, load_iru, load_irl, load_pc, incr_pc, fetch;
  logic store_mem, read_mem, push_ret, pop_ret, irq_ack;

  // Anything above 0x17, including any set bit above bit 7, is illegal.
  assign op        = bus.opcode[7:0];
  assign illegal   = bus.opcode > OPW'(8'h17);
  assign stk_full  = (sp_q == SPW'(STK_DEPTH));
  assign stk_empty = (sp_q == '0);
  assign irq_take  = bus.IRQ && !mask_q && !stk_full;

  always_comb begin
    state_d   = state_q;
    load_ac   = 1'b0;
    load_iru  = 1'b0;
    load_irl  = 1'b0;
    load_pc   = 1'b0;
    incr_pc   = 1'b0;
    fetch     = 1'b0;
    store_mem = 1'b0;
    read_mem  = 1'b0;
    push_ret  = 1'b0;
    pop_ret   = 1'b0;
    irq_ack   = 1'b0;

    unique case (state_q)
      S_START: begin
        load_ac = 1'b1;
        state_d = S_PREPU;
      end

      S_PREPU: begin
        fetch   = 1'b1;
        state_d = irq_take ? S_IRQ : S_FETCHU;
      end

      S_FETCHU: begin
        fetch = 1'b1;
        if (bus.MEM_READY) begin
          load_iru = 1'b1;
          incr_pc  = 1'b1;
          if (illegal) begin
            state_d = S_FAULT;
          end else begin
            case (op)
              8'h00:   state_d = S_PREPU;
              8'h04:   state_d = S_EXEC;
              8'h16:   state_d = stk_empty ? S_FAULT : S_RET;
              8'h17:   state_d = S_HALT;
              default: state_d = S_PREPL;
            endcase
          end
        end
      end

      S_PREPL: begin
        fetch = 1'b1;
        case (op)
          8'h10:   state_d = S_JUMP;
          8'h11:   state_d = bus.NFLG  ? S_JUMP : S_PREPU;
          8'h12:   state_d = !bus.NFLG ? S_JUMP : S_PREPU;
          8'h13:   state_d = bus.ZFLG  ? S_JUMP : S_PREPU;
          8'h14:   state_d = !bus.ZFLG ? S_JUMP : S_PREPU;
          8'h15:   state_d = stk_full  ? S_FAULT : S_CALL;
          default: state_d = S_FETCHL;
        endcase
      end

      S_FETCHL: begin
        fetch = 1'b1;
        if (bus.MEM_READY) begin
          load_irl = 1'b1;
          incr_pc  = 1'b1;
          case (op)
            8'h03:                               state_d = S_STOREMEM;
            8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F:   state_d = S_EXEC;
            default:                             state_d = S_READMEM;
          endcase
        end
      end

      S_READMEM: begin
        read_mem = 1'b1;
        if (bus.MEM_READY) state_d = S_EXEC;
      end

      S_STOREMEM: begin
        store_mem = 1'b1;
        if (bus.MEM_READY) state_d = S_PREPU;
      end

      S_EXEC: begin
        load_ac = 1'b1;
        state_d = S_PREPU;
      end

      S_JUMP: begin
        load_pc = 1'b1;
        state_d = S_PREPU;
      end

      S_CALL: begin
        load_pc  = 1'b1;
        push_ret = 1'b1;
        state_d  = S_PREPU;
      end

      S_RET: begin
        load_pc = 1'b1;
        pop_ret = 1'b1;
        state_d = S_PREPU;
      end

      S_IRQ: begin
        load_pc  = 1'b1;
        push_ret = 1'b1;
        irq_ack  = 1'b1;
        state_d  = S_PREPU;
      end

      S_HALT: begin
        if (irq_take) state_d = S_IRQ;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // Push/pop are never issued at the stack limits (Call/Ret/Irq entry is
  // guarded above), so the pointer cannot wrap.
  always_comb begin
    sp_d = sp_q;
    if (push_ret)     sp_d = sp_q + SPW'(1);
    else if (pop_ret) sp_d = sp_q - SPW'(1);
  end

  always_comb begin
    mask_d = mask_q;
    if (state_d == S_IRQ)      mask_d = 1'b1;
    else if (state_q == S_RET) mask_d = 1'b0;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= S_START;
      sp_q    <= '0;
      mask_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.LOAD_AC   = load_ac;
  assign bus.LOAD_IRU  = load_iru;
  assign bus.LOAD_IRL  = load_irl;
  assign bus.LOAD_PC   = load_pc;
  assign bus.INCR_PC   = incr_pc;
  assign bus.FETCH     = fetch;
  assign bus.STORE_MEM = store_mem;
  assign bus.READ_MEM  = read_mem;
  assign bus.PUSH_RET  = push_ret;
  assign bus.POP_RET   = pop_ret;
  assign bus.IRQ_ACK   = irq_ack;
  assign bus.SP        = sp_q;
  assign bus.STK_FULL  = stk_full;
  assign bus.STK_EMPTY = stk_empty;
  assign bus.HALTED    = (state_q == S_HALT);
  assign bus.FAULT     = (state_q == S_FAULT);
  assign bus.STATE     = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPW, default 8: opcode width; the opcode map uses opcode[7:0]; any nonzero bit above 7 is an illegal opcode.
REQ-002 Parameter STK_DEPTH, default 4: return-stack depth; minimum 1.
REQ-003 Parameter SPW, default $clog2(STK_DEPTH+1): width of the stack-pointer output.
REQ-004 clk  in  1  single clock; all registers update on its falling edge.
REQ-005 reset  in  1  synchronous, active-high; sampled on the falling edge of clk.
REQ-006 opcode  in  OPW  current instruction-register opcode.
REQ-007 NFLG, ZFLG  in  1 each  negative and zero flags from the datapath.
REQ-008 MEM_READY  in  1  memory completion; completes the current access on the cycle it is high.
REQ-009 IRQ  in  1  level interrupt request.
REQ-010 LOAD_AC, LOAD_IRU, LOAD_IRL, LOAD_PC, INCR_PC, FETCH, STORE_MEM, READ_MEM  out  1 each  datapath strobes.
REQ-011 PUSH_RET, POP_RET, IRQ_ACK  out  1 each  return-stack and interrupt strobes.
REQ-012 SP  out  SPW  return-stack occupancy; STK_FULL and STK_EMPTY  out  1 each.
REQ-013 HALTED, FAULT  out  1 each; STATE  out  4  current state encoding.

Function
REQ-014 State encoding: Start=0, PrepU=1, FetchU=2, PrepL=3, FetchL=4, Exec=5, StoreMem=6, ReadMem=7, Jump=8, Call=9, Ret=10, Irq=11, Halt=12, Fault=13; STATE equals the current state.
REQ-015 Start -> PrepU unconditionally; LOAD_AC=1 in Start.
REQ-016 PrepU -> Irq if IRQ=1, mask clear and STK_FULL=0; otherwise PrepU -> FetchU.
REQ-017 FetchU holds while MEM_READY=0. When MEM_READY=1 it decodes: 00 -> PrepU; 04 -> Exec; 16 -> Ret, or Fault if STK_EMPTY; 17 -> Halt; illegal -> Fault; any other opcode -> PrepL.
REQ-018 PrepL decode:
- 10 -> Jump.
- 11/12/13/14 -> Jump if NFLG / ~NFLG / ZFLG / ~ZFLG respectively, else PrepU.
- 15 -> Call, or Fault if STK_FULL.
- Any other opcode -> FetchL.
REQ-019 FetchL holds while MEM_READY=0. When MEM_READY=1: 03 -> StoreMem; 02, 06, 08, 0E, 0F -> Exec; any other opcode -> ReadMem.
REQ-020 ReadMem holds while MEM_READY=0, then -> Exec. StoreMem holds while MEM_READY=0, then -> PrepU.
REQ-021 Exec, Jump, Call, Ret and Irq each last 1 cycle, then -> PrepU.
REQ-022 Legal opcodes are 00–17 with the upper bits zero; any other value is illegal.
REQ-023 FETCH=1 in PrepU, FetchU, PrepL and FetchL.
REQ-024 LOAD_IRU=1 in FetchU only on the MEM_READY=1 cycle; LOAD_IRL=1 in FetchL only on the MEM_READY=1 cycle; INCR_PC=1 on both of those cycles.
REQ-025 READ_MEM=1 for every cycle of ReadMem; STORE_MEM=1 for every cycle of StoreMem.
REQ-026 LOAD_AC=1 in Start and Exec; LOAD_PC=1 in Jump, Call, Ret and Irq.
REQ-027 PUSH_RET=1 in Call and Irq; POP_RET=1 in Ret; IRQ_ACK=1 in Irq.
REQ-028 Return-stack pointer: SP increments by 1 on PUSH_RET and decrements by 1 on POP_RET. STK_FULL = (SP==STK_DEPTH); STK_EMPTY = (SP==0). SP never wraps; push-when-full and pop-when-empty are unreachable by construction.
REQ-029 Interrupt mask: set on entering Irq and cleared in Ret. IRQ is sampled only in PrepU and Halt, so an IRQ arriving mid-instruction waits for the next instruction boundary.
REQ-030 Halt: HALTED=1. Halt -> Irq when IRQ=1, mask clear and STK_FULL=0; otherwise Halt holds.
REQ-031 Fault: FAULT=1 and all strobes are 0; only reset exits Fault.
REQ-032 In every state, every strobe not listed above for that state is 0.

Reset
REQ-033 reset=1 at a falling edge forces state=Start, SP=0 and mask clear, overriding any transition, including mid-access with MEM_READY=0.
REQ-034 Outputs one cycle after reset: STATE=0, LOAD_AC=1, STK_EMPTY=1, SP=0; all other outputs 0.

Verification
REQ-035 NOP loop: opcode=00, MEM_READY=1 -> STATE sequence 0,1,2,1,2; LOAD_IRU=1 and INCR_PC=1 on each FetchU cycle.
REQ-036 Load with wait states: opcode=01, MEM_READY low for 3 cycles in both FetchL and ReadMem -> each state persists 4 cycles; LOAD_IRL asserts once; READ_MEM asserts for 4 cycles; then Exec with LOAD_AC=1.
REQ-037 Conditional jumps: opcode=11 with NFLG=1 -> PrepL->Jump, LOAD_PC=1; opcode=11 with NFLG=0 -> PrepL->PrepU, LOAD_PC=0.
REQ-038 Call/return with STK_DEPTH=2: 15, 15, 15 -> third CALL enters Fault with SP=2; after reset, 15 then 16 -> SP goes 0,1,0 with PUSH_RET then POP_RET pulses.
REQ-039 Interrupt: IRQ=1 during ReadMem -> no response until PrepU, then Irq with IRQ_ACK=1, PUSH_RET=1, SP+1; a second IRQ is ignored until 16 executes.
REQ-040 Halt and reset: opcode=17 -> HALTED=1, which holds with IRQ=0; IRQ=1 -> Irq. Also opcode=1F -> Fault; reset -> STATE=0.
